vram_arbiter: RTL and testbench

//  Shares the single-port synchronous video RAM between the ULA display fetch and CPU accesses.

---
 rtl/vram_arbiter.sv | 115 +++++++++++
 tb/tb_vram_arbiter.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : vram_arbiter
// Purpose  : Single-port VRAM sharing between ULA video fetch (fixed priority)
//            and CPU accesses that are stretched with cpuWait.
// Revision : 1.0
// ============================================================================
module vram_arbiter #(
  parameter int AW = 14,
  parameter int DW = 8,
  parameter int CW = 4
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          vidReq,
  input  logic [AW-1:0] vidAddr,
  output logic [DW-1:0] vidData,
  output logic          vidValid,
  input  logic          cpuReq,
  input  logic          cpuWr,
  input  logic [AW-1:0] cpuAddr,
  input  logic [DW-1:0] cpuDi,
  output logic [DW-1:0] cpuDo,
  output logic          cpuAck,
  output logic          cpuWait,
  output logic [CW-1:0] stallCnt,
  output logic [AW-1:0] memAddr,
  output logic [DW-1:0] memDi,
  output logic          memWe,
  input  logic [DW-1:0] memDo
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACK  = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic [CW-1:0] c_STALL_MAX = '1;

  state_t        r_state;
  logic          r_vidValid;
  logic          r_cpuAck;
  logic          r_wasRead;
  logic [DW-1:0] r_vidData;
  logic [DW-1:0] r_cpuDo;
  logic [CW-1:0] r_stallCnt;
  logic          w_grant;

  // The CPU owns the port only in an idle cycle that carries no video slot.
  assign w_grant  = (r_state == IDLE) && cpuReq && !vidReq && !reset;

  assign memAddr  = vidReq ? vidAddr : cpuAddr;
  assign memDi    = cpuDi;
  assign memWe    = w_grant && cpuWr;
  assign cpuWait  = cpuReq && (r_state == IDLE);

  assign vidValid = r_vidValid;
  assign cpuAck   = r_cpuAck;
  assign stallCnt = r_stallCnt;

  // RAM data arrives one cycle after the address, so it is forwarded straight
  // through while the strobe is high and held in a register afterwards.
  assign vidData  = r_vidValid ? memDo : r_vidData;
  assign cpuDo    = (r_cpuAck && r_wasRead) ? memDo : r_cpuDo;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= IDLE;
      r_vidValid <= 1'b0;
      r_cpuAck   <= 1'b0;
      r_wasRead  <= 1'b0;
      r_vidData  <= '0;
      r_cpuDo    <= '0;
      r_stallCnt <= '0;
    end else begin
      r_vidValid <= vidReq;
      r_cpuAck   <= 1'b0;
      if (r_vidValid) begin
        r_vidData <= memDo;
      end
      case (r_state)
        IDLE: begin
          if (!cpuReq) begin
            r_stallCnt <= '0;
          end else if (vidReq) begin
            if (r_stallCnt != c_STALL_MAX) begin
              r_stallCnt <= r_stallCnt + 1'b1;
            end
          end else begin
            r_cpuAck  <= 1'b1;
            r_wasRead <= !cpuWr;
            r_state   <= ACK;
          end
        end
        ACK: begin
          if (r_wasRead) begin
            r_cpuDo <= memDo;
          end
          r_stallCnt <= '0;
          r_state    <= HOLD;
        end
        HOLD: begin
          // One access per request: wait for the CPU to release before rearming.
          if (!cpuReq) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_vram_arbiter
// Purpose  : Scoreboard bench for vram_arbiter with a behavioural VRAM.
// Revision : 1.0
// ============================================================================
module tb_vram_arbiter;

  localparam int AW = 14;
  localparam int DW = 8;
  localparam int CW = 4;
  localparam int STALL_MAX = (1 << CW) - 1;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          vidReq = 1'b0;
  logic [AW-1:0] vidAddr = '0;
  logic [DW-1:0] vidData;
  logic          vidValid;
  logic          cpuReq = 1'b0;
  logic          cpuWr = 1'b0;
  logic [AW-1:0] cpuAddr = '0;
  logic [DW-1:0] cpuDi = '0;
  logic [DW-1:0] cpuDo;
  logic          cpuAck;
  logic          cpuWait;
  logic [CW-1:0] stallCnt;
  logic [AW-1:0] memAddr;
  logic [DW-1:0] memDi;
  logic          memWe;
  logic [DW-1:0] memDo;

  always #5 clock = ~clock;

  vram_arbiter #(.AW(AW), .DW(DW), .CW(CW)) dut (
    .clock(clock), .reset(reset),
    .vidReq(vidReq), .vidAddr(vidAddr), .vidData(vidData), .vidValid(vidValid),
    .cpuReq(cpuReq), .cpuWr(cpuWr), .cpuAddr(cpuAddr), .cpuDi(cpuDi),
    .cpuDo(cpuDo), .cpuAck(cpuAck), .cpuWait(cpuWait), .stallCnt(stallCnt),
    .memAddr(memAddr), .memDi(memDi), .memWe(memWe), .memDo(memDo)
  );

  // Synchronous single-port VRAM, read-before-write.
  logic [DW-1:0] ram [0:(1<<AW)-1];
  always @(posedge clock) begin
    memDo <= ram[memAddr];
    if (memWe) ram[memAddr] = memDi;
  end

  typedef struct {
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  exp_t vidQ[$];
  exp_t cpuQ[$];
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int weCount = 0;
  int ackCount = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  always @(posedge clock) cyc <= cyc + 1;

  // Reference model: what the memory holds, which request is already served,
  // how long it has been denied, and what each response must carry.
  logic [DW-1:0] refMem [0:(1<<AW)-1];
  bit            served = 1'b0;
  int            expStall = 0;
  logic [DW-1:0] lastRead = '0;
  bit            prevReq = 1'b0;
  logic [AW-1:0] prevAddr = '0;
  logic          prevWr = 1'b0;

  always @(negedge clock) begin
    exp_t t;
    if (cyc > 0) begin
      check("stallCnt", 32'(stallCnt), 32'(expStall));
      if (reset) begin
        check("memWe_in_reset", 32'(memWe), 32'd0);
        served   = 1'b0;
        expStall = 0;
        lastRead = '0;
      end else begin
        if (cpuReq && prevReq && (cpuAddr != prevAddr || cpuWr != prevWr))
          check("protocol_cpu_stable", 32'(cpuAddr), 32'(prevAddr));
        if (vidReq) begin
          check("memAddr_video", 32'(memAddr), 32'(vidAddr));
          t.data = refMem[vidAddr];
          t.due  = cyc + 1;
          vidQ.push_back(t);
        end
        if (!cpuReq) begin
          check("memWe_no_req", 32'(memWe), 32'd0);
          served   = 1'b0;
          expStall = 0;
        end else if (served) begin
          check("cpuWait_served", 32'(cpuWait), 32'd0);
          check("memWe_served", 32'(memWe), 32'd0);
          expStall = 0;
        end else if (vidReq) begin
          check("cpuWait_denied", 32'(cpuWait), 32'd1);
          check("memWe_denied", 32'(memWe), 32'd0);
          expStall = (expStall < STALL_MAX) ? expStall + 1 : STALL_MAX;
        end else begin
          check("cpuWait_grant", 32'(cpuWait), 32'd1);
          check("memAddr_cpu", 32'(memAddr), 32'(cpuAddr));
          check("memWe_grant", 32'(memWe), 32'(cpuWr));
          if (cpuWr) begin
            check("memDi_grant", 32'(memDi), 32'(cpuDi));
            refMem[cpuAddr] = cpuDi;
          end else begin
            lastRead = refMem[cpuAddr];
          end
          t.data = lastRead;
          t.due  = cyc + 1;
          cpuQ.push_back(t);
          served = 1'b1;
        end
      end
      prevReq  = cpuReq && !reset;
      prevAddr = cpuAddr;
      prevWr   = cpuWr;
    end
  end

  // Monitor: pops an expectation whenever the DUT presents a response.
  always @(negedge clock) begin
    exp_t e;
    if (cyc > 0) begin
      if (memWe) weCount++;
      if (cpuAck) ackCount++;
      if (vidValid) begin
        if (vidQ.size() == 0) check("vid_unexpected", 32'(vidValid), 32'd0);
        else begin
          e = vidQ.pop_front();
          check("vid_latency", 32'(cyc), 32'(e.due));
          check("vid_data", 32'(vidData), 32'(e.data));
        end
      end else if (vidQ.size() > 0 && vidQ[0].due <= cyc) begin
        void'(vidQ.pop_front());
        check("vid_missing", 32'(vidValid), 32'd1);
      end
      if (cpuAck) begin
        if (cpuQ.size() == 0) check("cpu_ack_unexpected", 32'(cpuAck), 32'd0);
        else begin
          e = cpuQ.pop_front();
          check("cpu_latency", 32'(cyc), 32'(e.due));
          check("cpu_data", 32'(cpuDo), 32'(e.data));
        end
      end else if (cpuQ.size() > 0 && cpuQ[0].due <= cyc) begin
        void'(cpuQ.pop_front());
        check("cpu_ack_missing", 32'(cpuAck), 32'd1);
      end
    end
  end

  // Comb outputs sampled mid-cycle by the driver for directed checks.
  logic [AW-1:0] sAddr;
  logic          sWe;

  task automatic tick(input logic vr, input logic [AW-1:0] va);
    vidReq  = vr;
    vidAddr = va;
    #1;
    sAddr = memAddr;
    sWe   = memWe;
    @(posedge clock);
    #1;
  endtask

  task automatic tickRand();
    tick(1'($urandom_range(0, 1)), AW'($urandom));
  endtask

  initial begin
    int we0;
    int ack0;
    bit got;
    for (int i = 0; i < (1 << AW); i++) begin
      ram[i]    = DW'($urandom);
      refMem[i] = ram[i];
    end
    ram[14'h1234]    = 8'hA5;
    refMem[14'h1234] = 8'hA5;

    // Reset held with both requesters active.
    reset = 1'b1; cpuReq = 1'b1; cpuWr = 1'b0; cpuAddr = 14'h0010;
    repeat (3) begin
      tick(1'b1, 14'h0020);
      check("rst_memWe", 32'(memWe), 32'd0);
      check("rst_cpuAck", 32'(cpuAck), 32'd0);
      check("rst_vidValid", 32'(vidValid), 32'd0);
      check("rst_stallCnt", 32'(stallCnt), 32'd0);
    end
    cpuReq = 1'b0;
    tick(1'b0, '0);
    reset = 1'b0;
    tick(1'b0, '0);
    tick(1'b0, '0);

    // Idle CPU read.
    cpuWr = 1'b0; cpuAddr = 14'h1234; cpuReq = 1'b1;
    tick(1'b0, '0);
    check("t2_memAddr", 32'(sAddr), 32'h1234);
    check("t2_ack", 32'(cpuAck), 32'd1);
    check("t2_cpuDo", 32'(cpuDo), 32'hA5);
    repeat (3) begin
      tick(1'b0, '0);
      check("t2_hold_noack", 32'(cpuAck), 32'd0);
      check("t2_hold_nowait", 32'(cpuWait), 32'd0);
    end
    cpuReq = 1'b0;
    tick(1'b0, '0);

    // Write contending with three video slots.
    we0 = weCount;
    cpuWr = 1'b1; cpuAddr = 14'h0800; cpuDi = 8'h3C; cpuReq = 1'b1;
    repeat (3) tick(1'b1, AW'($urandom));
    check("t3_stallCnt", 32'(stallCnt), 32'd3);
    check("t3_no_early_we", 32'(weCount - we0), 32'd0);
    tick(1'b0, '0);
    check("t3_we_4th", 32'(sWe), 32'd1);
    check("t3_we_count", 32'(weCount - we0), 32'd1);
    check("t3_ack", 32'(cpuAck), 32'd1);
    tick(1'b0, '0);
    cpuReq = 1'b0;
    tick(1'b0, '0);
    check("t3_ram", 32'(ram[14'h0800]), 32'h3C);

    // Simultaneous video and CPU read.
    cpuWr = 1'b0; cpuAddr = 14'h0001; cpuReq = 1'b1;
    tick(1'b1, 14'h1800);
    check("t4_memAddr_vid", 32'(sAddr), 32'h1800);
    check("t4_vidValid", 32'(vidValid), 32'd1);
    check("t4_cpu_not_yet", 32'(cpuAck), 32'd0);
    tick(1'b0, '0);
    check("t4_memAddr_cpu", 32'(sAddr), 32'h0001);
    check("t4_ack", 32'(cpuAck), 32'd1);
    tick(1'b0, '0);
    cpuReq = 1'b0;
    tick(1'b0, '0);

    // Write request held for ten cycles.
    we0 = weCount; ack0 = ackCount;
    cpuWr = 1'b1; cpuAddr = AW'($urandom); cpuDi = DW'($urandom); cpuReq = 1'b1;
    repeat (10) tick(1'b0, '0);
    cpuReq = 1'b0;
    tick(1'b0, '0);
    tick(1'b0, '0);
    check("t5_one_we", 32'(weCount - we0), 32'd1);
    check("t5_one_ack", 32'(ackCount - ack0), 32'd1);

    // Saturation, abort, and reset during ACK.
    we0 = weCount; ack0 = ackCount;
    cpuWr = 1'b0; cpuAddr = AW'($urandom); cpuReq = 1'b1;
    repeat (20) tick(1'b1, AW'($urandom));
    check("t6_saturate", 32'(stallCnt), 32'(STALL_MAX));
    cpuReq = 1'b0;
    tick(1'b1, AW'($urandom));
    check("t6_abort_clear", 32'(stallCnt), 32'd0);
    check("t6_abort_no_we", 32'(weCount - we0), 32'd0);
    check("t6_abort_no_ack", 32'(ackCount - ack0), 32'd0);
    we0 = weCount;
    cpuWr = 1'b1; cpuAddr = 14'h0100; cpuDi = 8'h77; cpuReq = 1'b1;
    tick(1'b0, '0);
    check("t6_ack_before_reset", 32'(cpuAck), 32'd1);
    reset = 1'b1;
    tick(1'b0, '0);
    tick(1'b0, '0);
    cpuReq = 1'b0;
    tick(1'b0, '0);
    reset = 1'b0;
    check("t6_single_we", 32'(weCount - we0), 32'd1);
    cpuWr = 1'b0; cpuAddr = 14'h0100; cpuReq = 1'b1;
    tick(1'b0, '0);
    check("t6_idle_after_reset", 32'(cpuAck), 32'd1);
    check("t6_readback", 32'(cpuDo), 32'h77);
    tick(1'b0, '0);
    cpuReq = 1'b0;
    tick(1'b0, '0);

    // Randomized traffic.
    for (int n = 0; n < 150; n++) begin
      cpuWr   = 1'($urandom_range(0, 1));
      cpuAddr = AW'($urandom);
      cpuDi   = DW'($urandom);
      cpuReq  = 1'b1;
      if ($urandom_range(0, 9) == 0) begin
        repeat ($urandom_range(1, 4)) tick(1'b1, AW'($urandom));
        cpuReq = 1'b0;
        tickRand();
      end else begin
        got = 1'b0;
        for (int k = 0; k < 64 && !got; k++) begin
          tickRand();
          got = cpuAck;
        end
        check("cpu_ack_within_bound", 32'(got), 32'd1);
        tickRand();
        repeat ($urandom_range(0, 2)) tickRand();
        cpuReq = 1'b0;
        repeat ($urandom_range(1, 3)) tickRand();
      end
    end

    cpuReq = 1'b0;
    repeat (3) tick(1'b0, '0);
    check("vidQ_drained", 32'(vidQ.size()), 32'd0);
    check("cpuQ_drained", 32'(cpuQ.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1);
  end

endmodule
`default_nettype wire
